// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   Operand-issue / writeback stage in front of a combinational ALU.
//   Accepts one micro-op (valid/ready), reads operands from a 2**ADDR_W x
//   DATA_W register file (x0 reads as zero), drives registered op/A/B to the
//   ALU, captures Result/Flag one edge later, then writes back. One op in
//   flight: IDLE -> EX -> WB -> IDLE, three cycles per op.
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   in_valid_i / in_ready_o   micro-op handshake (ready only in IDLE)
//   in_alu_op_i, in_rs1_i, in_rs2_i, in_rd_i, in_imm_i, in_use_imm_i
//   alu_op_o, alu_a_o, alu_b_o         registered ALU inputs
//   alu_result_i, alu_flag_i           ALU outputs, captured in EX
//   done_o, done_result_o, done_flag_o completion pulse + captured values
//   dbg_addr_i / dbg_data_o            combinational register-file peek
module alu_issue_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        in_alu_op_i,
  input  logic [ADDR_W-1:0] in_rs1_i,
  input  logic [ADDR_W-1:0] in_rs2_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  input  logic [DATA_W-1:0] in_imm_i,
  input  logic              in_use_imm_i,
  output logic [4:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_flag_i,
  output logic              done_o,
  output logic [DATA_W-1:0] done_result_o,
  output logic              done_flag_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, EX, WB} state_e;

  state_e              state_q, state_d;
  logic [4:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   wb_result_q, wb_result_d;
  logic                wb_flag_q, wb_flag_d;

  // Entry 0 is never written and is masked on every read port as well.
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   rs1_data, rs2_data;
  logic                rf_we;

  assign rs1_data   = (in_rs1_i   == '0) ? '0 : rf_q[in_rs1_i];
  assign rs2_data   = (in_rs2_i   == '0) ? '0 : rf_q[in_rs2_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

  // Compare/branch ops (11xxx) only produce a flag; they never write back.
  assign rf_we = (state_q == WB) && (alu_op_q[4:3] != 2'b11) && (rd_q != '0);

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rd_d        = rd_q;
    wb_result_d = wb_result_q;
    wb_flag_d   = wb_flag_q;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        alu_op_d = in_alu_op_i;
        alu_a_d  = rs1_data;
        alu_b_d  = in_use_imm_i ? in_imm_i : rs2_data;
        rd_d     = in_rd_i;
        state_d  = EX;
      end
      EX: begin
        wb_result_d = alu_result_i;
        wb_flag_d   = alu_flag_i;
        state_d     = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rd_q        <= '0;
      wb_result_q <= '0;
      wb_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rd_q        <= rd_d;
      wb_result_q <= wb_result_d;
      wb_flag_q   <= wb_flag_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd_q] <= wb_result_q;
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign done_o        = (state_q == WB);
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign done_result_o = wb_result_q;
  assign done_flag_o   = wb_flag_q;

endmodule

// File: tb/tb_alu_issue_regfile.sv
// Bench for alu_issue_regfile: a behavioural ALU stub feeds the DUT, a
// register-array model tracks architectural state, a vector table covers the
// directed sequence, then random ops and reset/hold corner cases follow.
module tb_alu_issue_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_alu_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_flag;
  logic        done;
  logic [31:0] done_result;
  logic        done_flag;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] mrf [32];

  always #5 clk = ~clk;

  alu_issue_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_alu_op_i(in_alu_op), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_rd_i(in_rd), .in_imm_i(in_imm), .in_use_imm_i(in_use_imm),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_flag_i(alu_flag),
    .done_o(done), .done_result_o(done_result), .done_flag_o(done_flag),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  // ALU behaviour: compare ops return the flag as a 0/1 result; unknown
  // codes produce a recognisable a ^ ~b pattern.
  function automatic logic cmp_fn(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      5'b11000: return a == b;
      5'b11001: return a != b;
      5'b11100: return $signed(a) <  $signed(b);
      5'b11101: return $signed(a) >= $signed(b);
      5'b11110: return a <  b;
      5'b11111: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (op[4:3] == 2'b11) return {31'd0, cmp_fn(op, a, b)};
    case (op)
      5'b00000: return a + b;
      5'b01000: return a - b;
      5'b00100: return a ^ b;
      5'b00110: return a | b;
      5'b00111: return a & b;
      5'b00001: return a << b[4:0];
      5'b00101: return a >> b[4:0];
      5'b01101: return $unsigned($signed(a) >>> b[4:0]);
      default:  return a ^ ~b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_flag   = cmp_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep_rf(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("%s x%0d", name, i), dbg_data, (i == 0) ? 32'd0 : mrf[i]);
    end
  endtask

  // Issue one op starting at a negedge; returns the captured result/flag.
  // in_* are scrambled right after acceptance to show they are ignored;
  // with hold=1 in_valid also stays high through EX.
  task automatic issue(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                       input logic hold, output logic [31:0] res, output logic flg);
    logic [31:0] ea, eb, er;
    logic        ef;
    int          n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready before issue", {31'd0, in_ready}, 32'd1);
    ea = (rs1 == 0) ? 32'd0 : mrf[rs1];
    eb = use_imm ? imm : ((rs2 == 0) ? 32'd0 : mrf[rs2]);
    er = alu_fn(op, ea, eb);
    ef = cmp_fn(op, ea, eb);
    in_valid = 1'b1; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_use_imm = use_imm;
    @(posedge clk); #1;
    in_valid = hold; in_alu_op = 5'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_rd = 5'($urandom); in_imm = $urandom;
    in_use_imm = 1'($urandom);
    @(negedge clk);
    chk("EX ready", {31'd0, in_ready}, 32'd0);
    chk("EX done",  {31'd0, done}, 32'd0);
    chk("EX alu_op", {27'd0, alu_op}, {27'd0, op});
    chk("EX alu_a", alu_a, ea);
    chk("EX alu_b", alu_b, eb);
    in_rd = 5'($urandom); in_imm = $urandom;
    @(negedge clk);
    chk("WB done", {31'd0, done}, 32'd1);
    chk("WB ready", {31'd0, in_ready}, 32'd0);
    chk("WB result", done_result, er);
    chk("WB flag", {31'd0, done_flag}, {31'd0, ef});
    res = done_result; flg = done_flag;
    in_valid = 1'b0;
    if (op[4:3] != 2'b11 && rd != 0) mrf[rd] = er;
    @(negedge clk);
    chk("post ready", {31'd0, in_ready}, 32'd1);
    chk("post done", {31'd0, done}, 32'd0);
    chk("post result hold", done_result, er);
    dbg_addr = rd; #1;
    chk($sformatf("post x%0d", rd), dbg_data, (rd == 0) ? 32'd0 : mrf[rd]);
  endtask

  typedef struct {
    logic [4:0]  op, rs1, rs2, rd;
    logic [31:0] imm;
    logic        use_imm;
    logic [31:0] exp_res;
    logic        exp_flag;
  } vec_t;

  vec_t tbl [9];
  logic [4:0] ops [15];

  initial begin
    logic [31:0] r;
    logic        f;
    int          pulses;

    tbl[0] = '{5'b00000, 5'd0, 5'd0, 5'd1, 32'd9,          1'b1, 32'd9,          1'b0};
    tbl[1] = '{5'b00000, 5'd0, 5'd0, 5'd2, 32'd8,          1'b1, 32'd8,          1'b0};
    tbl[2] = '{5'b00000, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'd17,         1'b0};
    tbl[3] = '{5'b01000, 5'd3, 5'd0, 5'd4, 32'd2,          1'b1, 32'd15,         1'b0};
    tbl[4] = '{5'b00000, 5'd0, 5'd0, 5'd6, 32'hFFFFFFF9,   1'b1, 32'hFFFFFFF9,   1'b0};
    tbl[5] = '{5'b01101, 5'd6, 5'd0, 5'd7, 32'd1,          1'b1, 32'hFFFFFFFC,   1'b0};
    tbl[6] = '{5'b11100, 5'd1, 5'd4, 5'd5, 32'd0,          1'b0, 32'd1,          1'b1};
    tbl[7] = '{5'b11100, 5'd4, 5'd1, 5'd5, 32'd0,          1'b0, 32'd0,          1'b0};
    tbl[8] = '{5'b00000, 5'd0, 5'd0, 5'd0, 32'd5,          1'b1, 32'd5,          1'b0};
    ops = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101,
            5'b01101, 5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111,
            5'b00010};

    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    in_valid = 0; in_alu_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_imm = 0; in_use_imm = 0; dbg_addr = 0;

    // Reset asserted mid-cycle, checked while held.
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst ready", {31'd0, in_ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst done_result", done_result, 32'd0);
    chk("rst done_flag", {31'd0, done_flag}, 32'd0);
    sweep_rf("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].use_imm, 1'b0, r, f);
      chk($sformatf("vec%0d result", i), r, tbl[i].exp_res);
      chk($sformatf("vec%0d flag", i), {31'd0, f}, {31'd0, tbl[i].exp_flag});
    end
    dbg_addr = 5'd5; #1; chk("branch no write x5", dbg_data, 32'd0);
    dbg_addr = 5'd0; #1; chk("x0 stays zero", dbg_data, 32'd0);

    // Valid held through EX/WB with changing inputs: only one op executes.
    issue(5'b00000, 5'd0, 5'd0, 5'd9, 32'h1234, 1'b1, 1'b1, r, f);
    chk("hold result", r, 32'h1234);
    @(negedge clk);
    chk("hold no second accept", {31'd0, in_ready}, 32'd1);
    sweep_rf("hold");

    // Random ops against the model.
    for (int k = 0; k < 40; k++) begin
      issue(ops[$urandom_range(0, 14)], 5'($urandom), 5'($urandom), 5'($urandom),
            $urandom, 1'($urandom), 1'($urandom), r, f);
    end
    sweep_rf("rand");

    // Reset during EX aborts the op: no done pulse, no writeback.
    in_valid = 1'b1; in_alu_op = 5'b00000; in_rs1 = 0; in_rs2 = 0;
    in_rd = 5'd8; in_imm = 32'd3; in_use_imm = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("abort in EX", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort done pulses", pulses, 0);
    chk("abort ready", {31'd0, in_ready}, 32'd1);
    chk("abort alu_a", alu_a, 32'd0);
    chk("abort done_result", done_result, 32'd0);
    sweep_rf("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_regfile.md
Name: alu_issue_regfile

Overview:
- Operand-issue and writeback stage directly upstream of the ALU.
- Accepts one decoded ALU micro-op via a valid/ready handshake and reads operands from a 32x32 register file; x0 is hardwired to zero.
- Drives registered ALUOp/A/B into the ALU, captures Result/Flag on the next edge, then writes the result back to the register file.
- Strictly one op in flight: 3 cycles per op, no hazards and no forwarding.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  micro-op valid
- in_ready_o  out  1  stage can accept a micro-op
- in_alu_op_i  in  5  ALU operation code (ALU encoding)
- in_rs1_i  in  ADDR_W  source register A
- in_rs2_i  in  ADDR_W  source register B
- in_rd_i  in  ADDR_W  destination register
- in_imm_i  in  DATA_W  immediate
- in_use_imm_i  in  1  1: B = imm; 0: B = rf[rs2]
- alu_op_o  out  5  to ALU ALUOp
- alu_a_o  out  DATA_W  to ALU A
- alu_b_o  out  DATA_W  to ALU B
- alu_result_i  in  DATA_W  from ALU Result
- alu_flag_i  in  1  from ALU Flag
- done_o  out  1  one-cycle completion pulse
- done_result_o  out  DATA_W  captured Result, valid while done_o
- done_flag_o  out  1  captured Flag (branch taken), valid while done_o
- dbg_addr_i  in  ADDR_W  debug read address
- dbg_data_o  out  DATA_W  combinational rf[dbg_addr_i]; always 0 for address 0

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; all register-file entries = 0.
  - alu_op_o, alu_a_o, alu_b_o = 0; done_o = 0; done_result_o = 0; done_flag_o = 0.
  - Any op in progress is aborted with no writeback.
- FSM states: IDLE, EX, WB.
- in_ready_o = (state == IDLE), decoded combinationally from state.
- IDLE:
  - Stays in IDLE while in_valid_i = 0.
  - On in_valid_i = 1, accepts the op and registers:
    - alu_op_o <= in_alu_op_i
    - alu_a_o <= rf[rs1]
    - alu_b_o <= in_use_imm_i ? in_imm_i : rf[rs2]
    - rd <= in_rd_i
  - Register reads use the register-file contents present at the accept edge; rs = 0 reads 0.
  - Next state: EX.
- EX:
  - ALU evaluates combinationally from alu_*_o.
  - At the edge: wb_result <= alu_result_i, wb_flag <= alu_flag_i.
  - Next state: WB.
- WB:
  - done_o = 1; done_result_o and done_flag_o hold the captured values.
  - Write enable = (alu_op[4:3] != 2'b11) && (rd != 0). Compare/branch ops (11xxx) never write.
  - rf[rd] updates at the WB exit edge.
  - Next state: IDLE.
- Latency: accept edge T → done_o high during cycle T+2 → new register value visible on dbg_data_o and to the next accept from T+3.
- Throughput: one op per 3 cycles.
- A dependent op issued back-to-back reads the written value; no bypass is required.
- in_valid_i and all in_* inputs are ignored in EX and WB. The upstream holds them; the op is accepted on return to IDLE.
- alu_op/a/b and done_result_o/done_flag_o hold their values until the next accept or capture; done_o is low outside WB.
- Undefined ALUOp codes pass through unchanged; the result is whatever the ALU returns, written per the normal write-enable rule.
- Arithmetic is mod 2**DATA_W. The immediate is used as-is (sign extension is done upstream).

Test Plan:
- Reset: assert rst_ni=0 mid-cycle → dbg x0..x31 = 0, in_ready_o=1, done_o=0, alu_* = 0.
- Immediate loads, ADD 00000:
  - rs1=0, use_imm, imm=9, rd=1 → in_ready_o low 2 cycles, done_o pulses at T+2, done_result=9, dbg x1=9.
  - Same with imm=8, rd=2 → x2=8.
  - Register ADD x3 = x1+x2 → 17.
- SUB 01000: x4 = x3 − imm 2 → 15.
- SRA 01101: load x6 = 0xFFFFFFF9, then imm 1 → result 0xFFFFFFFC in x7.
- Branch compare 11100 (lts), x1(9) < x4(15), rd=5 → done_flag_o=1, x5 stays 0.
- Same op 11100 with x4 < x1 → done_flag_o=0.
- ADD imm 5, rd=0 → done_result=5, dbg x0 = 0.
- Hold in_valid_i high through EX/WB with changing in_* → only the first op is executed.
- Pulse rst_ni low during EX of "ADD x8 = imm 3" → x8 = 0, state IDLE, done_o never pulses.
